// File: rtl/io_fifo_port.sv
// io_fifo_port: memory-mapped responder on the processor data bus.
// Holds an LED register, a synchronised switch input and a write FIFO
// that the processor fills and an external consumer drains via valid/ready.
// Register map (ADDR[1:0]): 0 DATA, 1 STATUS, 2 LED, 3 SW.
module io_fifo_port #(
  parameter logic [3:0] BASE  = 4'h1,
  parameter int         DEPTH = 8,
  parameter int         AW    = 3
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic [15:0] ADDR,
  input  logic [15:0] DOUT,
  input  logic        W,
  input  logic [9:0]  SW,
  output logic [15:0] RDATA,
  output logic        RSEL,
  output logic [9:0]  LEDR,
  output logic [15:0] q_data,
  output logic        q_valid,
  input  logic        q_ready
);

  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1'b1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1'b1);

  // Registered state
  logic [15:0]   mem_r [DEPTH];
  logic [AW-1:0] wptr_r;
  logic [AW-1:0] rptr_r;
  logic [AW:0]   count_r;
  logic          ovf_r;
  logic [9:0]    ledr_r;
  logic [9:0]    sw_meta_r;
  logic [9:0]    sw_sync_r;
  logic [15:0]   rdata_r;
  logic          rsel_r;

  // Decode and FIFO control
  logic          sel_s;
  logic [1:0]    off_s;
  logic          push_req_s;
  logic          flush_s;
  logic          clr_ovf_s;
  logic          led_wr_s;
  logic          empty_s;
  logic          full_s;
  logic          pop_s;
  logic          do_push_s;
  logic          ovf_set_s;
  logic [AW:0]   count_nxt_s;
  logic [7:0]    cnt8_s;
  logic [15:0]   rd_mux_s;

  // Address decode, handshake qualification and FIFO next-count
  always_comb begin
    sel_s       = (ADDR[15:12] == BASE);
    off_s       = ADDR[1:0];
    push_req_s  = W & sel_s & (off_s == 2'd0);
    flush_s     = W & sel_s & (off_s == 2'd1) & DOUT[0];
    clr_ovf_s   = W & sel_s & (off_s == 2'd1) & DOUT[1];
    led_wr_s    = W & sel_s & (off_s == 2'd2);
    empty_s     = (count_r == '0);
    full_s      = (count_r == DEPTH_C);
    pop_s       = (~empty_s) & q_ready;
    // A push into a full FIFO still lands if the head leaves on the same edge.
    do_push_s   = push_req_s & ((~full_s) | pop_s);
    ovf_set_s   = push_req_s & full_s & (~pop_s);
    count_nxt_s = count_r;
    case ({do_push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_ONE;
      2'b01:   count_nxt_s = count_r - CNT_ONE;
      default: count_nxt_s = count_r;
    endcase
  end

  // Read-data multiplexer over the four registers
  always_comb begin
    cnt8_s         = 8'h00;
    cnt8_s[AW:0]   = count_r;
    rd_mux_s       = 16'h0000;
    case (off_s)
      2'd0: begin
        if (empty_s) begin
          rd_mux_s = 16'h0000;
        end else begin
          rd_mux_s = mem_r[rptr_r];
        end
      end
      2'd1:    rd_mux_s = {cnt8_s, 5'b00000, ovf_r, full_s, empty_s};
      2'd2:    rd_mux_s = {6'b000000, ledr_r};
      2'd3:    rd_mux_s = {6'b000000, sw_sync_r};
      default: rd_mux_s = 16'h0000;
    endcase
  end

  // FIFO storage; not reset, only written by an accepted push
  always_ff @(posedge Clock) begin
    if (do_push_s && !flush_s) begin
      mem_r[wptr_r] <= DOUT;
    end
  end

  // FIFO pointers, count and sticky overflow; flush beats push/pop
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      wptr_r  <= '0;
      rptr_r  <= '0;
      count_r <= '0;
      ovf_r   <= 1'b0;
    end else begin
      if (flush_s) begin
        wptr_r  <= '0;
        rptr_r  <= '0;
        count_r <= '0;
      end else begin
        if (do_push_s) begin
          wptr_r <= wptr_r + PTR_ONE;
        end
        if (pop_s) begin
          rptr_r <= rptr_r + PTR_ONE;
        end
        count_r <= count_nxt_s;
      end
      // Clearing wins over a same-cycle overflow.
      if (clr_ovf_s) begin
        ovf_r <= 1'b0;
      end else if (ovf_set_s) begin
        ovf_r <= 1'b1;
      end
    end
  end

  // LED register
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      ledr_r <= 10'h000;
    end else if (led_wr_s) begin
      ledr_r <= DOUT[9:0];
    end
  end

  // Two-flop synchroniser for the asynchronous switches
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      sw_meta_r <= 10'h000;
      sw_sync_r <= 10'h000;
    end else begin
      sw_meta_r <= SW;
      sw_sync_r <= sw_meta_r;
    end
  end

  // Registered read port: one cycle after ADDR, from pre-edge state
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      rdata_r <= 16'h0000;
      rsel_r  <= 1'b0;
    end else begin
      rdata_r <= rd_mux_s;
      rsel_r  <= sel_s;
    end
  end

  assign RDATA   = rdata_r;
  assign RSEL    = rsel_r;
  assign LEDR    = ledr_r;
  assign q_data  = mem_r[rptr_r];
  assign q_valid = (count_r != '0);

endmodule

// File: tb/tb_io_fifo_port.sv
// Directed testbench for io_fifo_port: register map, FIFO order, overflow,
// wrap, full push/pop, flush, LED/SW, decode and asynchronous reset.
module tb_io_fifo_port;

  logic        Clock;
  logic        Resetn;
  logic [15:0] ADDR;
  logic [15:0] DOUT;
  logic        W;
  logic [9:0]  SW;
  logic [15:0] RDATA;
  logic        RSEL;
  logic [9:0]  LEDR;
  logic [15:0] q_data;
  logic        q_valid;
  logic        q_ready;

  int n_vec = 0;
  int n_err = 0;
  logic [15:0] model_q [$];

  io_fifo_port #(.BASE(4'h1), .DEPTH(8), .AW(3)) dut (
    .Clock   (Clock),
    .Resetn  (Resetn),
    .ADDR    (ADDR),
    .DOUT    (DOUT),
    .W       (W),
    .SW      (SW),
    .RDATA   (RDATA),
    .RSEL    (RSEL),
    .LEDR    (LEDR),
    .q_data  (q_data),
    .q_valid (q_valid),
    .q_ready (q_ready)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check_vec(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h", tag, obs, exp);
    end
  endtask

  // One-cycle bus write; called 1 time unit after a rising edge.
  task automatic bus_write(input logic [15:0] addr, input logic [15:0] data);
    ADDR = addr;
    DOUT = data;
    W    = 1'b1;
    @(posedge Clock);
    #1;
    W    = 1'b0;
  endtask

  // Bus read: RDATA/RSEL are sampled after the capturing edge.
  task automatic bus_read(input string tag, input logic [15:0] addr, input logic [15:0] exp);
    logic exp_sel;
    ADDR = addr;
    W    = 1'b0;
    exp_sel = (addr[15:12] == 4'h1);
    @(posedge Clock);
    #1;
    check_vec({tag, "_rsel"}, {15'd0, RSEL}, {15'd0, exp_sel});
    if (exp_sel) begin
      check_vec(tag, RDATA, exp);
    end
  endtask

  // One FIFO cycle at the DATA register with optional push and pop;
  // a queue scoreboard supplies the expected head word.
  task automatic fifo_cycle(input logic do_push, input logic [15:0] data, input logic do_pop);
    logic full_pre;
    logic popped;
    ADDR    = 16'h1000;
    DOUT    = data;
    W       = do_push;
    q_ready = do_pop;
    #1;
    full_pre = (model_q.size() == 8);
    popped   = 1'b0;
    if (do_pop && model_q.size() > 0) begin
      check_vec("q_valid", {15'd0, q_valid}, 16'h0001);
      check_vec("q_data", q_data, model_q[0]);
    end
    @(posedge Clock);
    if (do_pop && model_q.size() > 0) begin
      void'(model_q.pop_front());
      popped = 1'b1;
    end
    if (do_push && (!full_pre || popped)) begin
      model_q.push_back(data);
    end
    #1;
    W       = 1'b0;
    q_ready = 1'b0;
  endtask

  initial begin
    Resetn  = 1'b0;
    ADDR    = 16'h0000;
    DOUT    = 16'h0000;
    W       = 1'b0;
    q_ready = 1'b0;
    SW      = 10'h3FF;

    // Reset state
    repeat (3) @(posedge Clock);
    #1;
    check_vec("rst_rdata", RDATA, 16'h0000);
    check_vec("rst_rsel", {15'd0, RSEL}, 16'h0000);
    check_vec("rst_ledr", {6'd0, LEDR}, 16'h0000);
    check_vec("rst_qvalid", {15'd0, q_valid}, 16'h0000);
    Resetn = 1'b1;
    repeat (3) @(posedge Clock);
    #1;
    bus_read("sw_read", 16'h1003, 16'h03FF);
    bus_read("empty_data", 16'h1000, 16'h0000);

    // Three pushes, no consumer
    bus_write(16'h1000, 16'h1111);
    bus_write(16'h1000, 16'h2222);
    bus_write(16'h1000, 16'h3333);
    bus_read("stat3", 16'h1001, 16'h0300);
    bus_read("head3", 16'h1000, 16'h1111);
    check_vec("qdata3", q_data, 16'h1111);
    check_vec("qvalid3", {15'd0, q_valid}, 16'h0001);
    model_q = '{16'h1111, 16'h2222, 16'h3333};
    for (int i = 0; i < 3; i++) fifo_cycle(1'b0, 16'h0000, 1'b1);
    bus_read("stat_drained", 16'h1001, 16'h0001);

    // Overflow: 9 pushes into an 8-deep FIFO
    for (int i = 1; i <= 9; i++) fifo_cycle(1'b1, 16'(i), 1'b0);
    bus_read("stat_ovf", 16'h1001, 16'h0806);
    for (int i = 0; i < 8; i++) fifo_cycle(1'b0, 16'h0000, 1'b1);
    check_vec("ovf_dropped", {15'd0, q_valid}, 16'h0000);
    bus_read("stat_ovf_empty", 16'h1001, 16'h0005);
    bus_write(16'h1001, 16'h0002);
    bus_read("stat_ovf_clr", 16'h1001, 16'h0001);

    // Pointer wrap with concurrent push/pop
    for (int k = 0; k < 20; k++) fifo_cycle(1'b1, 16'h0100 + 16'(k), (k >= 3));
    for (int i = 0; i < 3; i++) fifo_cycle(1'b0, 16'h0000, 1'b1);
    bus_read("stat_wrap", 16'h1001, 16'h0001);

    // Full plus simultaneous push and pop
    for (int k = 0; k < 8; k++) fifo_cycle(1'b1, 16'hA000 + 16'(k), 1'b0);
    fifo_cycle(1'b1, 16'hAAAA, 1'b1);
    bus_read("stat_full_pp", 16'h1001, 16'h0802);
    for (int i = 0; i < 7; i++) fifo_cycle(1'b0, 16'h0000, 1'b1);
    check_vec("last_word", q_data, 16'hAAAA);
    fifo_cycle(1'b0, 16'h0000, 1'b1);
    bus_read("stat_full_done", 16'h1001, 16'h0001);

    // LED register and SW write ignored
    bus_write(16'h1002, 16'h02A5);
    check_vec("ledr_wr", {6'd0, LEDR}, 16'h02A5);
    bus_read("led_read", 16'h1002, 16'h02A5);
    bus_write(16'h1003, 16'h0155);
    check_vec("ledr_sw_wr", {6'd0, LEDR}, 16'h02A5);
    bus_read("led_alias", 16'h1FF2, 16'h02A5);

    // Flush with consumer ready
    for (int k = 0; k < 5; k++) fifo_cycle(1'b1, 16'hB000 + 16'(k), 1'b0);
    q_ready = 1'b1;
    bus_write(16'h1001, 16'h0001);
    check_vec("flush_qvalid", {15'd0, q_valid}, 16'h0000);
    q_ready = 1'b0;
    model_q.delete();
    bus_read("stat_flush", 16'h1001, 16'h0001);

    // Out-of-region accesses
    bus_write(16'h2000, 16'h5555);
    bus_write(16'h0002, 16'h0000);
    bus_read("sel_2000", 16'h2000, 16'h0000);
    bus_read("sel_0000", 16'h0000, 16'h0000);
    check_vec("sel_ledr", {6'd0, LEDR}, 16'h02A5);
    bus_read("sel_stat", 16'h1001, 16'h0001);

    // Reset asserted mid-drain
    for (int k = 0; k < 3; k++) fifo_cycle(1'b1, 16'hC000 + 16'(k), 1'b0);
    q_ready = 1'b1;
    @(posedge Clock);
    #3;
    Resetn = 1'b0;
    #1;
    check_vec("rst_mid_qvalid", {15'd0, q_valid}, 16'h0000);
    check_vec("rst_mid_ledr", {6'd0, LEDR}, 16'h0000);
    check_vec("rst_mid_rsel", {15'd0, RSEL}, 16'h0000);
    q_ready = 1'b0;
    model_q.delete();
    @(posedge Clock);
    #1;
    Resetn = 1'b1;
    bus_read("stat_after_rst", 16'h1001, 16'h0001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/io_fifo_port.md
# io_fifo_port

Memory-mapped bus responder on the processor's data bus: it decodes the processor's registered `ADDR`/`DOUT`/`W` outputs and returns registered read data for merging into the processor's `DIN`. It holds an LED register, a synchronised switch input and a write FIFO. The processor pushes 16-bit words into the FIFO; an external consumer drains it with a valid/ready handshake. It sits beside the synchronous instruction/data memory in the top-level system.

## Interface
- `BASE`, default 4'h1: `ADDR[15:12]` value that selects this block.
- `DEPTH`, default 8: FIFO entries; power of two, 2..128.
- `AW`, default 3: log2(`DEPTH`).
- `Clock`  in  1: single clock, all state on rising edge.
- `Resetn`  in  1: asynchronous, active-low reset.
- `ADDR`  in  16: processor address; held stable for the whole access.
- `DOUT`  in  16: processor write data.
- `W`  in  1: write strobe; a write commits on a rising edge with `W`=1.
- `SW`  in  10: asynchronous slide switches.
- `RDATA`  out  16: registered read data.
- `RSEL`  out  1: registered; 1 when `RDATA` belongs to this block. The top level steers `DIN` with it.
- `LEDR`  out  10: LED register.
- `q_data`  out  16: FIFO head word.
- `q_valid`  out  1: FIFO non-empty.
- `q_ready`  in  1: consumer accepts the head when `q_valid`=1.

## Operation
- Select: `sel` = (`ADDR[15:12]` == `BASE`). Register offset is `ADDR[1:0]`. `ADDR[11:2]` is ignored, so the block aliases across its 4K region.
- Offset 0, DATA:
  - Write pushes `DOUT`.
  - Read returns the head word without popping, or 0 when the FIFO is empty.
- Offset 1, STATUS:
  - Read returns {count zero-extended to 8 bits [15:8], 5'b0, overflow [2], full [1], empty [0]}.
  - Write: `DOUT[0]`=1 flushes the FIFO (count 0, pointers 0). `DOUT[1]`=1 clears overflow. Other bits are ignored.
- Offset 2, LED: write loads `DOUT[9:0]` into `LEDR`. Read returns {6'b0, `LEDR`}.
- Offset 3, SW: read returns {6'b0, synced `SW`}. Writes are ignored.
- FIFO structure: circular buffer with `AW`-bit read and write pointers that wrap modulo `DEPTH`, and an (`AW`+1)-bit count.
  - empty = (count==0); full = (count==`DEPTH`).
- push = `W` & `sel` & offset 0. pop = `q_valid` & `q_ready`.
  - Push when not full: writes the word and increments the write pointer.
  - Push when full without a same-cycle pop: the word is dropped and sticky overflow is set.
  - Push and pop in the same cycle: both occur and count is unchanged. This also applies when full, where it is not an overflow. It cannot occur when empty, because `q_valid`=0.
- Priority order in one cycle: flush > push/pop. A flush discards any concurrent push and pop, and the consumer's handshake in that cycle has no effect.
- Overflow priority: a clear-overflow write wins over a same-cycle overflow set.
- `q_data` = memory[rptr], combinational from the registered state. It is undefined-but-stable when empty; the bench must not check it when `q_valid`=0.
- `SW` passes through a 2-flop synchroniser per bit.

## Timing
- Reset values (asynchronous, immediate on `Resetn`=0): `RDATA`=0, `RSEL`=0, `LEDR`=0, count=0, pointers=0, overflow=0, synchroniser flops=0, `q_valid`=0. FIFO storage is not reset.
- Read latency is 1 cycle. Every edge captures `RDATA` <= mux(`ADDR`) from pre-edge state, and `RSEL` <= `sel`.
  - This matches the processor's one wait cycle after loading `ADDR`.
  - A read in the same cycle as a write to the same register returns the old value.
- Writes take effect at the edge where `W`=1. Status, `LEDR` and `q_valid` reflect the write on the next cycle.
- Pop: the head advances at the edge with `q_valid`&`q_ready`. `q_valid` falls in the cycle after the last word is popped.
- `SW` latency: 2 cycles to the synchroniser output, plus 1 cycle to `RDATA`.
- Reset asserted mid-transfer: all state clears at once. The FIFO contents are lost and the in-progress write is not performed.

## Test plan
- Reset: hold `Resetn`=0 with `SW`=10'h3FF -> `RDATA`=0, `RSEL`=0, `LEDR`=0, `q_valid`=0. After release and 3 cycles, a read of 0x1003 returns 0x03FF.
- Push 0x1111, 0x2222, 0x3333 to 0x1000 with `q_ready`=0:
  - Read 0x1001 returns 0x0300.
  - Read 0x1000 returns 0x1111.
  - `q_data`=0x1111 and `q_valid`=1.
  - Hold `q_ready`=1 for 3 cycles -> pops 0x1111, 0x2222, 0x3333 in order; status returns 0x0001.
- Overflow and wrap: push 9 words 0x0001..0x0009 with `q_ready`=0:
  - Status returns 0x0806 (count 8, full, overflow).
  - Drain returns 0x0001..0x0008.
  - Write 0x0002 to 0x1001 -> status returns 0x0001.
  - Push/pop 20 more words -> order preserved across pointer wrap.
- Full plus simultaneous push/pop: fill to 8 words, then push 0xAAAA while `q_ready`=1 -> count stays 8, overflow stays 0, and 0xAAAA is the last word drained.
- LED and flush:
  - Write 0x02A5 to 0x1002 -> `LEDR`=10'h2A5 next cycle; read returns 0x02A5. Write to 0x1003 -> `LEDR` is unchanged.
  - With 5 words queued, write 0x0001 to 0x1001 while `q_ready`=1 -> `q_valid`=0 next cycle and status returns 0x0001.
- Select: access 0x2000 or 0x0000 -> `RSEL`=0 and no state change. Reset asserted mid-drain -> `q_valid`=0 immediately.
